// File: rtl/reorder_buffer.sv
// In-order retirement buffer: hands out completion indices at decode, collects
// tagged results and retires them in program order, flushing on an excepting head.
module reorder_buffer #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4,
    parameter int XLEN    = 32,
    parameter int EXC_W   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_alloc_valid,
    input  logic [4:0]       in_alloc_rd,
    input  logic             in_alloc_write_enable,
    input  logic [XLEN-1:0]  in_alloc_PC,
    output logic             out_alloc_ready,
    output logic [IDX_W-1:0] out_alloc_idx,
    input  logic             in_complete_valid,
    input  logic [IDX_W-1:0] in_complete_idx,
    input  logic [XLEN-1:0]  in_complete_result,
    input  logic [EXC_W-1:0] in_complete_exception_vector,
    input  logic             in_commit_stall,
    input  logic             in_flush,
    output logic             out_commit_valid,
    output logic [IDX_W-1:0] out_commit_idx,
    output logic [4:0]       out_commit_rd,
    output logic [XLEN-1:0]  out_commit_data,
    output logic             out_commit_write_enable,
    output logic [XLEN-1:0]  out_commit_PC,
    output logic             out_exception_valid,
    output logic [EXC_W-1:0] out_exception_vector,
    output logic [XLEN-1:0]  out_exception_PC,
    output logic             out_flush,
    output logic             out_full,
    output logic             out_empty,
    output logic [IDX_W:0]   out_count
);

    localparam logic [IDX_W:0]   FULL_COUNT = ENTRIES[IDX_W:0];
    localparam logic [IDX_W:0]   CNT_ONE    = 1;
    localparam logic [IDX_W-1:0] IDX_ONE    = 1;

    logic             r_valid    [ENTRIES];
    logic             r_complete [ENTRIES];
    logic [4:0]       r_rd       [ENTRIES];
    logic             r_we       [ENTRIES];
    logic [XLEN-1:0]  r_pc       [ENTRIES];
    logic [XLEN-1:0]  r_result   [ENTRIES];
    logic [EXC_W-1:0] r_exc      [ENTRIES];

    logic [IDX_W-1:0] r_head;
    logic [IDX_W-1:0] r_tail;
    logic [IDX_W:0]   r_count;

    logic             r_commit_valid;
    logic [IDX_W-1:0] r_commit_idx;
    logic [4:0]       r_commit_rd;
    logic [XLEN-1:0]  r_commit_data;
    logic             r_commit_we;
    logic [XLEN-1:0]  r_commit_pc;
    logic             r_exc_valid;
    logic [EXC_W-1:0] r_exc_vector;
    logic [XLEN-1:0]  r_exc_pc;
    logic             r_flush;

    logic             w_head_ready;
    logic             w_exc_pending;
    logic             w_commit;
    logic             w_alloc;
    logic             w_full;
    logic [IDX_W:0]   w_count_next;

    // Commit decisions look only at registered entry state, so a completion
    // arriving this cycle cannot retire before the next one.
    always_comb begin
        w_head_ready    = r_valid[r_head] && r_complete[r_head] && !in_commit_stall;
        w_exc_pending   = w_head_ready && (r_exc[r_head] != '0);
        w_commit        = w_head_ready && (r_exc[r_head] == '0);
        w_full          = (r_count == FULL_COUNT);
        out_alloc_ready = !w_full && !w_exc_pending && !in_flush;
        w_alloc         = in_alloc_valid && out_alloc_ready;
        case ({w_alloc, w_commit})
            2'b10:   w_count_next = r_count + CNT_ONE;
            2'b01:   w_count_next = r_count - CNT_ONE;
            default: w_count_next = r_count;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]    <= 1'b0;
                r_complete[i] <= 1'b0;
                r_rd[i]       <= '0;
                r_we[i]       <= 1'b0;
                r_pc[i]       <= '0;
                r_result[i]   <= '0;
                r_exc[i]      <= '0;
            end
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_commit_valid <= 1'b0;
            r_commit_idx   <= '0;
            r_commit_rd    <= '0;
            r_commit_data  <= '0;
            r_commit_we    <= 1'b0;
            r_commit_pc    <= '0;
            r_exc_valid    <= 1'b0;
            r_exc_vector   <= '0;
            r_exc_pc       <= '0;
            r_flush        <= 1'b0;
        end else if (in_flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]    <= 1'b0;
                r_complete[i] <= 1'b0;
            end
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_commit_valid <= 1'b0;
            r_commit_we    <= 1'b0;
            r_exc_valid    <= 1'b0;
            r_flush        <= 1'b0;
        end else if (w_exc_pending) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]    <= 1'b0;
                r_complete[i] <= 1'b0;
            end
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_commit_valid <= 1'b0;
            r_commit_we    <= 1'b0;
            r_exc_valid    <= 1'b1;
            r_exc_vector   <= r_exc[r_head];
            r_exc_pc       <= r_pc[r_head];
            r_flush        <= 1'b1;
        end else begin
            r_exc_valid    <= 1'b0;
            r_flush        <= 1'b0;
            r_commit_valid <= w_commit;
            r_commit_we    <= w_commit && r_we[r_head];
            if (in_complete_valid && r_valid[in_complete_idx]) begin
                r_complete[in_complete_idx] <= 1'b1;
                r_result[in_complete_idx]   <= in_complete_result;
                r_exc[in_complete_idx]      <= in_complete_exception_vector;
            end
            // Retiring clears the head after any same-cycle completion to it.
            if (w_commit) begin
                r_commit_idx       <= r_head;
                r_commit_rd        <= r_rd[r_head];
                r_commit_data      <= r_result[r_head];
                r_commit_pc        <= r_pc[r_head];
                r_valid[r_head]    <= 1'b0;
                r_complete[r_head] <= 1'b0;
                r_head             <= r_head + IDX_ONE;
            end
            if (w_alloc) begin
                r_valid[r_tail]    <= 1'b1;
                r_complete[r_tail] <= 1'b0;
                r_rd[r_tail]       <= in_alloc_rd;
                r_we[r_tail]       <= in_alloc_write_enable;
                r_pc[r_tail]       <= in_alloc_PC;
                r_exc[r_tail]      <= '0;
                r_tail             <= r_tail + IDX_ONE;
            end
            r_count <= w_count_next;
        end
    end

    assign out_alloc_idx           = r_tail;
    assign out_commit_valid        = r_commit_valid;
    assign out_commit_idx          = r_commit_idx;
    assign out_commit_rd           = r_commit_rd;
    assign out_commit_data         = r_commit_data;
    assign out_commit_write_enable = r_commit_we;
    assign out_commit_PC           = r_commit_pc;
    assign out_exception_valid     = r_exc_valid;
    assign out_exception_vector    = r_exc_vector;
    assign out_exception_PC        = r_exc_pc;
    assign out_flush               = r_flush;
    assign out_full                = w_full;
    assign out_empty               = (r_count == '0);
    assign out_count               = r_count;

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based reference model.
module tb_reorder_buffer;

    localparam int ENTRIES = 16;
    localparam int IDX_W   = 4;
    localparam int XLEN    = 32;
    localparam int EXC_W   = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             allocValid;
    logic [4:0]       allocRd;
    logic             allocWe;
    logic [XLEN-1:0]  allocPc;
    logic             allocReady;
    logic [IDX_W-1:0] allocIdx;
    logic             completeValid;
    logic [IDX_W-1:0] completeIdx;
    logic [XLEN-1:0]  completeResult;
    logic [EXC_W-1:0] completeExc;
    logic             commitStall;
    logic             flushIn;
    logic             commitValid;
    logic [IDX_W-1:0] commitIdx;
    logic [4:0]       commitRd;
    logic [XLEN-1:0]  commitData;
    logic             commitWe;
    logic [XLEN-1:0]  commitPc;
    logic             excValid;
    logic [EXC_W-1:0] excVector;
    logic [XLEN-1:0]  excPc;
    logic             flushOut;
    logic             full;
    logic             empty;
    logic [IDX_W:0]   count;

    always #5 clk = ~clk;

    reorder_buffer #(.ENTRIES(ENTRIES), .IDX_W(IDX_W), .XLEN(XLEN), .EXC_W(EXC_W)) dut (
        .clk(clk), .reset(reset),
        .in_alloc_valid(allocValid), .in_alloc_rd(allocRd),
        .in_alloc_write_enable(allocWe), .in_alloc_PC(allocPc),
        .out_alloc_ready(allocReady), .out_alloc_idx(allocIdx),
        .in_complete_valid(completeValid), .in_complete_idx(completeIdx),
        .in_complete_result(completeResult), .in_complete_exception_vector(completeExc),
        .in_commit_stall(commitStall), .in_flush(flushIn),
        .out_commit_valid(commitValid), .out_commit_idx(commitIdx),
        .out_commit_rd(commitRd), .out_commit_data(commitData),
        .out_commit_write_enable(commitWe), .out_commit_PC(commitPc),
        .out_exception_valid(excValid), .out_exception_vector(excVector),
        .out_exception_PC(excPc), .out_flush(flushOut),
        .out_full(full), .out_empty(empty), .out_count(count)
    );

    // Reference model: the in-flight instructions in program order; element k
    // owns index (mHead + k) mod ENTRIES.
    typedef struct {
        logic [4:0]       rd;
        logic             we;
        logic [XLEN-1:0]  pc;
        logic             done;
        logic [XLEN-1:0]  result;
        logic [EXC_W-1:0] exc;
    } entryT;

    entryT model[$];
    int    mHead = 0;

    logic             eCv, eWe, eEv, eFl;
    logic [IDX_W-1:0] eIdx;
    logic [4:0]       eRd;
    logic [XLEN-1:0]  eData, ePc, eEpc;
    logic [EXC_W-1:0] eVec;

    int nChecks = 0;
    int nFails  = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic bit modelExcPending();
        if (model.size() == 0) return 1'b0;
        return model[0].done && (model[0].exc != '0) && !commitStall;
    endfunction

    task automatic checkComb();
        bit expReady;
        expReady = (model.size() < ENTRIES) && !modelExcPending() && !flushIn;
        checkOutput("alloc_ready", allocReady, expReady);
        checkOutput("alloc_idx", allocIdx, (mHead + model.size()) % ENTRIES);
        checkOutput("count", count, model.size());
        checkOutput("full", full, model.size() == ENTRIES);
        checkOutput("empty", empty, model.size() == 0);
    endtask

    task automatic modelStep();
        int    oldSize;
        int    oldHead;
        int    off;
        bit    ready;
        bit    headReady;
        entryT e;
        oldSize   = model.size();
        oldHead   = mHead;
        ready     = (oldSize < ENTRIES) && !modelExcPending() && !flushIn;
        headReady = (oldSize > 0) && model[0].done && !commitStall;
        eCv = 1'b0; eWe = 1'b0; eEv = 1'b0; eFl = 1'b0;
        if (flushIn) begin
            model.delete();
            mHead = 0;
        end else if (headReady && model[0].exc != '0) begin
            eEv = 1'b1; eFl = 1'b1;
            eVec = model[0].exc;
            eEpc = model[0].pc;
            model.delete();
            mHead = 0;
        end else begin
            if (headReady) begin
                eCv   = 1'b1;
                eWe   = model[0].we;
                eIdx  = IDX_W'(oldHead);
                eRd   = model[0].rd;
                eData = model[0].result;
                ePc   = model[0].pc;
            end
            if (completeValid) begin
                off = (int'(completeIdx) - oldHead + ENTRIES) % ENTRIES;
                if (off < oldSize) begin
                    model[off].done   = 1'b1;
                    model[off].result = completeResult;
                    model[off].exc    = completeExc;
                end
            end
            if (headReady) begin
                void'(model.pop_front());
                mHead = (mHead + 1) % ENTRIES;
            end
            if (allocValid && ready) begin
                e.rd = allocRd; e.we = allocWe; e.pc = allocPc;
                e.done = 1'b0; e.result = '0; e.exc = '0;
                model.push_back(e);
            end
        end
    endtask

    task automatic checkRegs();
        checkOutput("commit_valid", commitValid, eCv);
        checkOutput("commit_we", commitWe, eWe);
        checkOutput("exception_valid", excValid, eEv);
        checkOutput("flush_out", flushOut, eFl);
        if (eCv) begin
            checkOutput("commit_idx", commitIdx, eIdx);
            checkOutput("commit_rd", commitRd, eRd);
            checkOutput("commit_data", commitData, eData);
            checkOutput("commit_pc", commitPc, ePc);
        end
        if (eEv) begin
            checkOutput("exception_vector", excVector, eVec);
            checkOutput("exception_pc", excPc, eEpc);
        end
    endtask

    // One clock: drive at the falling edge, check combinational outputs, step
    // the model, then check the registered outputs just after the rising edge.
    task automatic applyStimulus(input bit av, input logic [4:0] rd, input bit we, input logic [31:0] pc,
                                 input bit cv, input logic [3:0] cidx, input logic [31:0] cres,
                                 input logic [2:0] cexc, input bit stall, input bit fl);
        @(negedge clk);
        allocValid = av; allocRd = rd; allocWe = we; allocPc = pc;
        completeValid = cv; completeIdx = cidx; completeResult = cres; completeExc = cexc;
        commitStall = stall; flushIn = fl;
        #1;
        checkComb();
        modelStep();
        @(posedge clk);
        #1;
        checkRegs();
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic alloc(input logic [4:0] rd, input logic [31:0] pc);
        applyStimulus(1, rd, 1, pc, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic complete(input logic [3:0] idx, input logic [31:0] res, input logic [2:0] exc);
        applyStimulus(0, 0, 0, 0, 1, idx, res, exc, 0, 0);
    endtask

    task automatic checkAllRegsZero(input string tag);
        checkOutput({tag, "_commit_valid"}, commitValid, 0);
        checkOutput({tag, "_commit_we"}, commitWe, 0);
        checkOutput({tag, "_exception_valid"}, excValid, 0);
        checkOutput({tag, "_flush_out"}, flushOut, 0);
        checkOutput({tag, "_count"}, count, 0);
        checkOutput({tag, "_empty"}, empty, 1);
    endtask

    task automatic applyReset();
        @(negedge clk);
        reset = 1'b0;
        allocValid = 0; allocRd = 0; allocWe = 0; allocPc = 0;
        completeValid = 0; completeIdx = 0; completeResult = 0; completeExc = 0;
        commitStall = 0; flushIn = 0;
        repeat (2) @(negedge clk);
        checkAllRegsZero("in_reset");
        checkOutput("in_reset_commit_data", commitData, 0);
        checkOutput("in_reset_exception_pc", excPc, 0);
        reset = 1'b1;
        model.delete();
        mHead = 0;
        #1;
        checkOutput("post_reset_alloc_ready", allocReady, 1);
        checkOutput("post_reset_alloc_idx", allocIdx, 0);
    endtask

    typedef struct {
        bit               av;
        logic [4:0]       rd;
        logic [XLEN-1:0]  pc;
        bit               cv;
        logic [IDX_W-1:0] cidx;
        logic [XLEN-1:0]  cres;
        bit               expCv;
        logic [IDX_W-1:0] expIdx;
        logic [4:0]       expRd;
        logic [XLEN-1:0]  expData;
        int               expCount;
    } vecT;

    vecT vecs[9];

    initial begin
        reset = 1'b0;
        vecs[0] = '{1, 5'd1, 32'h0, 0, 4'd0, 32'h0,  0, 4'd0, 5'd0, 32'h0,  1};
        vecs[1] = '{1, 5'd2, 32'h4, 0, 4'd0, 32'h0,  0, 4'd0, 5'd0, 32'h0,  2};
        vecs[2] = '{1, 5'd3, 32'h8, 0, 4'd0, 32'h0,  0, 4'd0, 5'd0, 32'h0,  3};
        vecs[3] = '{0, 5'd0, 32'h0, 1, 4'd2, 32'hA2, 0, 4'd0, 5'd0, 32'h0,  3};
        vecs[4] = '{0, 5'd0, 32'h0, 1, 4'd0, 32'hA0, 0, 4'd0, 5'd0, 32'h0,  3};
        vecs[5] = '{0, 5'd0, 32'h0, 1, 4'd1, 32'hA1, 1, 4'd0, 5'd1, 32'hA0, 2};
        vecs[6] = '{0, 5'd0, 32'h0, 0, 4'd0, 32'h0,  1, 4'd1, 5'd2, 32'hA1, 1};
        vecs[7] = '{0, 5'd0, 32'h0, 0, 4'd0, 32'h0,  1, 4'd2, 5'd3, 32'hA2, 0};
        vecs[8] = '{0, 5'd0, 32'h0, 0, 4'd0, 32'h0,  0, 4'd0, 5'd0, 32'h0,  0};

        applyReset();

        $display("[TB] in-order commit table");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].av, vecs[i].rd, 1, vecs[i].pc, vecs[i].cv, vecs[i].cidx,
                          vecs[i].cres, 0, 0, 0);
            checkOutput("tbl_commit_valid", commitValid, vecs[i].expCv);
            checkOutput("tbl_count", count, vecs[i].expCount);
            if (vecs[i].expCv) begin
                checkOutput("tbl_commit_idx", commitIdx, vecs[i].expIdx);
                checkOutput("tbl_commit_rd", commitRd, vecs[i].expRd);
                checkOutput("tbl_commit_data", commitData, vecs[i].expData);
                checkOutput("tbl_commit_we", commitWe, 1);
            end
        end

        $display("[TB] full and wrap-around");
        applyReset();
        for (int i = 0; i < ENTRIES; i++) alloc(5'(i), 32'(i * 4));
        checkOutput("full_flag", full, 1);
        checkOutput("full_alloc_ready", allocReady, 0);
        alloc(5'd31, 32'hDEAD);
        checkOutput("full_17th_count", count, 16);
        complete(4'd0, 32'h1234, 0);
        idle();
        checkOutput("wrap_commit_valid", commitValid, 1);
        checkOutput("wrap_commit_idx", commitIdx, 0);
        checkOutput("wrap_alloc_idx", allocIdx, 0);
        alloc(5'd7, 32'h40);
        checkOutput("wrap_count", count, 16);

        $display("[TB] exception flush");
        applyReset();
        alloc(5'd5, 32'h100);
        alloc(5'd6, 32'h104);
        complete(4'd1, 32'h11, 3'b000);
        complete(4'd0, 32'h22, 3'b010);
        idle();
        checkOutput("exc_valid", excValid, 1);
        checkOutput("exc_vector", excVector, 3'b010);
        checkOutput("exc_pc", excPc, 32'h100);
        checkOutput("exc_flush", flushOut, 1);
        checkOutput("exc_no_commit", commitValid, 0);
        checkOutput("exc_empty", empty, 1);
        checkOutput("exc_alloc_idx", allocIdx, 0);
        idle();

        $display("[TB] commit stall");
        applyReset();
        alloc(5'd9, 32'h200);
        complete(4'd0, 32'h55, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            checkOutput("stall_no_commit", commitValid, 0);
        end
        idle();
        checkOutput("stall_release_commit", commitValid, 1);
        checkOutput("stall_release_data", commitData, 32'h55);

        $display("[TB] asynchronous reset mid-flight");
        applyReset();
        for (int i = 0; i < 5; i++) alloc(5'(i + 1), 32'(16 * i));
        complete(4'd0, 32'h77, 0);
        idle();
        checkOutput("pre_areset_commit", commitValid, 1);
        #2;
        reset = 1'b0;
        #1;
        checkAllRegsZero("areset");
        model.delete();
        mHead = 0;
        #10;
        reset = 1'b1;
        repeat (4) idle();

        $display("[TB] randomized traffic");
        applyReset();
        for (int n = 0; n < 3000; n++) begin
            bit          av, cv, st, fl;
            logic [3:0]  ci;
            logic [2:0]  ce;
            av = ($urandom % 3) != 0;
            cv = ($urandom % 2) != 0;
            st = ($urandom % 5) == 0;
            fl = ($urandom % 60) == 0;
            ce = (($urandom % 16) == 0) ? 3'(1 + $urandom % 7) : 3'b000;
            if (model.size() > 0 && ($urandom % 4) != 0)
                ci = 4'((mHead + int'($urandom % model.size())) % ENTRIES);
            else
                ci = 4'($urandom);
            applyStimulus(av, 5'($urandom), 1'($urandom), $urandom, cv, ci, $urandom, ce, st, fl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- In-order retirement buffer that issues the 4-bit completion index the ID/EX stage carries down the pipeline.
- It is the other end of that index: it allocates an entry at decode and returns its index. Completions come back tagged with the index plus result and exception vector. Entries commit strictly in program order to the register file.
- An excepting head entry flushes the whole buffer and raises an exception pulse.

Parameters:
- ENTRIES, 16: number of entries; must be a power of two.
- IDX_W, 4: index width, log2(ENTRIES).
- XLEN, 32: data and PC width.
- EXC_W, 3: exception vector width.

Ports:
- clk  in  1: clock; all state updates on posedge.
- reset  in  1: asynchronous, active-low reset.
- in_alloc_valid  in  1: decode requests an entry.
- in_alloc_rd  in  5: destination register.
- in_alloc_write_enable  in  1: entry writes rd.
- in_alloc_PC  in  XLEN: instruction PC.
- out_alloc_ready  out  1: allocation accepted this cycle (combinational).
- out_alloc_idx  out  IDX_W: index granted, equal to the tail (combinational).
- in_complete_valid  in  1: completion strobe.
- in_complete_idx  in  IDX_W: completing entry.
- in_complete_result  in  XLEN: result data.
- in_complete_exception_vector  in  EXC_W: nonzero means exception.
- in_commit_stall  in  1: hold commit (e.g. d-cache stall).
- in_flush  in  1: external flush, e.g. mispredict.
- out_commit_valid  out  1: registered retire pulse.
- out_commit_idx  out  IDX_W: retired index.
- out_commit_rd  out  5: retired destination register.
- out_commit_data  out  XLEN: retired result.
- out_commit_write_enable  out  1: register file write enable; equals entry write_enable AND out_commit_valid.
- out_commit_PC  out  XLEN: retired PC.
- out_exception_valid  out  1: registered exception pulse.
- out_exception_vector  out  EXC_W: exception cause.
- out_exception_PC  out  XLEN: PC of the excepting instruction.
- out_flush  out  1: registered one-cycle flush pulse to the pipeline.
- out_full  out  1: count == ENTRIES.
- out_empty  out  1: count == 0.
- out_count  out  IDX_W+1: occupancy.

Behaviour:
- Per-entry state: valid, complete, rd, write_enable, PC, result, exc. Pointers: head, tail, each IDX_W bits, wrapping mod ENTRIES. Count is IDX_W+1 bits.
- Reset (reset==0, asynchronous):
  - head=tail=count=0; all valid and complete bits cleared.
  - Every registered output = 0.
  - Therefore out_empty=1, out_alloc_idx=0, out_alloc_ready=1 once reset deasserts.
- Allocation:
  - out_alloc_ready = !out_full && !exc_pending && !in_flush.
  - exc_pending = head valid && complete && exc!=0 && !in_commit_stall.
  - On valid && ready: write the tail entry with valid=1, complete=0, exc=0; tail++.
  - Full blocks allocation even when a commit happens in the same cycle.
- Completion:
  - If in_complete_valid and the entry at in_complete_idx is valid: complete<=1, result and exc captured.
  - Completion to an invalid entry is ignored.
  - A repeat completion overwrites the captured result.
- Commit evaluation, each cycle, using registered state only:
  - A completion in cycle N makes the entry commit-eligible at cycle N+1. Minimum complete-to-commit latency is therefore 2 edges.
  - If head valid && complete && !in_commit_stall:
    - exc==0: out_commit_valid<=1 with the entry fields; clear the entry; head++.
    - exc!=0: out_exception_valid<=1, out_exception_vector<=exc, out_exception_PC<=PC, out_flush<=1, out_commit_valid<=0. Invalidate all entries; head=tail=0.
  - Otherwise out_commit_valid, out_exception_valid and out_flush are driven 0 (they are single-cycle pulses).
  - At most one commit per cycle.
- in_flush:
  - Highest priority after reset.
  - Invalidates all entries; head=tail=count=0.
  - Drives out_commit_valid=0 and out_exception_valid=0; does not pulse out_flush.
  - Same-cycle allocation and completion are discarded.
- Count update: count += accepted alloc − commit. Simultaneous alloc and commit leaves count unchanged.
- Wrap-around: an index of 15 is followed by 0. Indices stay unique because count is never allowed to exceed ENTRIES.

Test Plan:
- Reset held low, then released -> all outputs 0, out_empty=1, out_alloc_idx=0, out_alloc_ready=1.
- Allocate 3 entries (rd 1,2,3; PC 0x0,0x4,0x8), then complete idx 2, 0, 1 on successive cycles -> commits idx 0,1,2 in order on consecutive cycles with matching rd and data, out_commit_write_enable=1.
- Allocate 16 entries -> out_full=1, out_alloc_ready=0, a 17th request is not accepted. Complete and commit idx 0, then allocate -> granted idx 0 (wrap), count returns to 16.
- Allocate idx 0 (PC 0x100) and idx 1; complete 1 normally and 0 with exc 3'b010 -> one-cycle out_exception_valid=1, vector 010, PC 0x100, out_flush=1, no commit. Next cycle out_empty=1 and out_alloc_idx=0.
- Complete head while in_commit_stall=1 for 3 cycles -> no commit; commit occurs on the first cycle after the stall releases.
- Pulse reset low asynchronously between edges while 5 entries are in flight -> outputs clear immediately, count=0, no spurious commit after release.
